mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. Consumes the EX/MEM pipeline-register outputs, performs data-memory loads and stores over a request/acknowledge port with variable latency, aligns and sign/zero-extends load data, and registers the write-back payload for the MEM/WB boundary. While an access is outstanding it holds the pipeline via `mem_stall`. A cycle-budget timeout converts a hung access into a bus-error write-back.

---
 rtl/mem_stage.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
// Issues data-memory loads/stores over a req/ack port with variable latency.
// It aligns and extends load data and registers the MEM/WB write-back payload.
// It stalls upstream while an access is outstanding.
// A cycle budget turns a hung access into a bus-error write-back.
//
// Ports:
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   valid, mem_is_*_dmem      EX/MEM slot live / store / load
//   mem_wb_select             00 ALU, 01 load, 10 link, 11 none
//   mem_write_width           access size mask (01/03/0F/FF, others -> FF)
//   mem_load_unsigned         zero-extend loads
//   mem_addr, mem_dmem_write_data, mem_link_addr, mem_rd   EX/MEM payload
//   dmem_*                    data-memory request/acknowledge port
//   mem_stall                 hold EX/MEM and upstream stages
//   wb_*                      registered write-back payload and exception flags
module mem_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            valid,
  input  logic            mem_is_write_dmem,
  input  logic            mem_is_read_dmem,
  input  logic [1:0]      mem_wb_select,
  input  logic [7:0]      mem_write_width,
  input  logic            mem_load_unsigned,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_dmem_write_data,
  input  logic [XLEN-1:0] mem_link_addr,
  input  logic [4:0]      mem_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [7:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      wb_select,
  output logic            wb_misaligned,
  output logic            wb_bus_error
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request registers captured at issue; they drive the port while waiting.
  logic [XLEN-1:0]   addr_q, wdata_q, link_q;
  logic [7:0]        size_q;
  logic              we_q, uns_q;
  logic [4:0]        rd_q;
  logic [1:0]        sel_q;

  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [1:0]        wb_select_q, wb_select_d;
  logic              wb_mis_q, wb_mis_d;
  logic              wb_berr_q, wb_berr_d;

  logic [7:0]        size_norm;
  logic              misaligned;
  logic              is_mem;
  logic              issue;
  logic              timeout;
  logic              complete;

  logic [XLEN-1:0]   cur_addr, cur_wdata, cur_link;
  logic [7:0]        cur_size;
  logic              cur_we, cur_uns;
  logic [4:0]        cur_rd;
  logic [1:0]        cur_sel;
  logic [XLEN-1:0]   load_data;

  // Align the selected bytes to bit 0, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] extract_load(input logic [XLEN-1:0] rdata,
                                                   input logic [2:0]      off,
                                                   input logic [7:0]      size,
                                                   input logic            uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (size)
      8'h01:   res = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                         : {{(XLEN-8){sh[7]}}, sh[7:0]};
      8'h03:   res = uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                         : {{(XLEN-16){sh[15]}}, sh[15:0]};
      8'h0F:   res = uns ? {{(XLEN-32){1'b0}}, sh[31:0]}
                         : {{(XLEN-32){sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0]      sel,
                                             input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld,
                                             input logic [XLEN-1:0] link);
    logic [XLEN-1:0] res;
    case (sel)
      2'b00:   res = alu;
      2'b01:   res = ld;
      2'b10:   res = link;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Size normalization and alignment check on the incoming instruction.
  always_comb begin
    case (mem_write_width)
      8'h01, 8'h03, 8'h0F, 8'hFF: size_norm = mem_write_width;
      default:                    size_norm = 8'hFF;
    endcase
    case (size_norm)
      8'h01:   misaligned = 1'b0;
      8'h03:   misaligned = mem_addr[0];
      8'h0F:   misaligned = |mem_addr[1:0];
      default: misaligned = |mem_addr[2:0];
    endcase
    is_mem = valid & (mem_is_write_dmem | mem_is_read_dmem);
  end

  // Port source: live inputs in IDLE, latched request while waiting.
  always_comb begin
    if (state_q == ST_WAIT) begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_link  = link_q;
      cur_size  = size_q;
      cur_we    = we_q;
      cur_uns   = uns_q;
      cur_rd    = rd_q;
      cur_sel   = sel_q;
    end else begin
      cur_addr  = mem_addr;
      cur_wdata = mem_dmem_write_data;
      cur_link  = mem_link_addr;
      cur_size  = size_norm;
      cur_we    = mem_is_write_dmem;
      cur_uns   = mem_load_unsigned;
      cur_rd    = mem_rd;
      cur_sel   = mem_wb_select;
    end
    dmem_addr  = {cur_addr[XLEN-1:3], 3'b000};
    dmem_wmask = cur_we ? 8'(cur_size << cur_addr[2:0]) : 8'h00;
    dmem_wdata = cur_wdata << {cur_addr[2:0], 3'b000};
    load_data  = extract_load(dmem_rdata, cur_addr[2:0], cur_size, cur_uns);
  end

  // Next-state, request/stall control and write-back payload.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_req    = 1'b0;
    mem_stall   = 1'b0;
    issue       = 1'b0;
    complete    = 1'b0;
    timeout     = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
    wb_valid_d  = 1'b0;
    wb_rd_d     = '0;
    wb_data_d   = '0;
    wb_select_d = '0;
    wb_mis_d    = 1'b0;
    wb_berr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = mem_rd;
            wb_select_d = 2'b11;
            wb_mis_d    = 1'b1;
          end else begin
            dmem_req = 1'b1;
            issue    = 1'b1;
            if (dmem_ack) begin
              complete = 1'b1;
            end else begin
              mem_stall = 1'b1;
              state_d   = ST_WAIT;
              cnt_d     = '0;
            end
          end
        end else if (valid) begin
          wb_valid_d  = 1'b1;
          wb_rd_d     = mem_rd;
          wb_select_d = mem_wb_select;
          wb_data_d   = wb_mux(mem_wb_select, mem_addr, '0, mem_link_addr);
        end
      end
      ST_WAIT: begin
        if (timeout) begin
          state_d     = ST_IDLE;
          wb_valid_d  = 1'b1;
          wb_rd_d     = rd_q;
          wb_select_d = 2'b11;
          wb_berr_d   = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            mem_stall = 1'b1;
            cnt_d     = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      wb_valid_d  = 1'b1;
      wb_rd_d     = cur_rd;
      wb_select_d = cur_sel;
      wb_data_d   = wb_mux(cur_sel, cur_addr, load_data, cur_link);
    end

    // No request is presented in a cycle where reset is being sampled.
    if (sys_rst) dmem_req = 1'b0;
  end

  assign dmem_we = dmem_req & cur_we;

  // State, request capture and write-back registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      link_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_select_q <= '0;
      wb_mis_q    <= 1'b0;
      wb_berr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_dmem_write_data;
        link_q  <= mem_link_addr;
        size_q  <= size_norm;
        we_q    <= mem_is_write_dmem;
        uns_q   <= mem_load_unsigned;
        rd_q    <= mem_rd;
        sel_q   <= mem_wb_select;
      end
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_select_q <= wb_select_d;
      wb_mis_q    <= wb_mis_d;
      wb_berr_q   <= wb_berr_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign wb_select     = wb_select_q;
  assign wb_misaligned = wb_mis_q;
  assign wb_bus_error  = wb_berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected write-backs are queued at drive time
// and matched against every wb_valid pulse.
module tb_mem_stage;

  logic        sys_clk;
  logic        sys_rst;
  logic        valid;
  logic        mem_is_write_dmem;
  logic        mem_is_read_dmem;
  logic [1:0]  mem_wb_select;
  logic [7:0]  mem_write_width;
  logic        mem_load_unsigned;
  logic [63:0] mem_addr;
  logic [63:0] mem_dmem_write_data;
  logic [63:0] mem_link_addr;
  logic [4:0]  mem_rd;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_wmask;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  wb_select;
  logic        wb_misaligned;
  logic        wb_bus_error;

  mem_stage #(.XLEN(64), .TIMEOUT(16)) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .valid               (valid),
    .mem_is_write_dmem   (mem_is_write_dmem),
    .mem_is_read_dmem    (mem_is_read_dmem),
    .mem_wb_select       (mem_wb_select),
    .mem_write_width     (mem_write_width),
    .mem_load_unsigned   (mem_load_unsigned),
    .mem_addr            (mem_addr),
    .mem_dmem_write_data (mem_dmem_write_data),
    .mem_link_addr       (mem_link_addr),
    .mem_rd              (mem_rd),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wmask          (dmem_wmask),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .wb_valid            (wb_valid),
    .wb_rd               (wb_rd),
    .wb_data             (wb_data),
    .wb_select           (wb_select),
    .wb_misaligned       (wb_misaligned),
    .wb_bus_error        (wb_bus_error)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  sel;
    logic        mis;
    logic        berr;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      n_assert = 0;
  int      n_fail   = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [63:0] data,
                           input logic [1:0] sel, input logic mis, input logic berr);
    wb_exp_t e;
    e.rd   = rd;
    e.data = data;
    e.sel  = sel;
    e.mis  = mis;
    e.berr = berr;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic set_op(input logic we, input logic re, input logic [7:0] width,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] link, input logic [4:0] rd, input logic [1:0] sel);
    valid               = 1'b1;
    mem_is_write_dmem   = we;
    mem_is_read_dmem    = re;
    mem_write_width     = width;
    mem_load_unsigned   = uns;
    mem_addr            = addr;
    mem_dmem_write_data = wdata;
    mem_link_addr       = link;
    mem_rd              = rd;
    mem_wb_select       = sel;
  endtask

  task automatic set_idle();
    valid             = 1'b0;
    mem_is_write_dmem = 1'b0;
    mem_is_read_dmem  = 1'b0;
    dmem_ack          = 1'b0;
  endtask

  // Scoreboard: every write-back pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {63'd0, wb_valid}, 64'd0);
      end else begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_select", 64'(wb_select), 64'(e.sel));
        chk("wb_misaligned", 64'(wb_misaligned), 64'(e.mis));
        chk("wb_bus_error", 64'(wb_bus_error), 64'(e.berr));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int reqs;
    bit done;

    sys_rst = 1'b1;
    set_idle();
    mem_wb_select       = 2'b00;
    mem_write_width     = 8'h00;
    mem_load_unsigned   = 1'b0;
    mem_addr            = '0;
    mem_dmem_write_data = '0;
    mem_link_addr       = '0;
    mem_rd              = '0;
    dmem_rdata          = '0;
    tick();
    tick();
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_select", 64'(wb_select), 64'd0);
    chk("rst_wb_flags", {62'd0, wb_misaligned, wb_bus_error}, 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    sys_rst = 1'b0;
    tick();

    // Store byte, ack in the request cycle.
    set_op(1'b1, 1'b0, 8'h01, 1'b0, 64'h1003, 64'hAB, 64'h0, 5'd3, 2'b11);
    dmem_ack = 1'b1;
    expect_wb(5'd3, 64'd0, 2'b11, 1'b0, 1'b0);
    #1;
    chk("sb_req", {62'd0, dmem_req, dmem_we}, 64'd3);
    chk("sb_addr", dmem_addr, 64'h1000);
    chk("sb_wmask", 64'(dmem_wmask), 64'h08);
    chk("sb_wdata", dmem_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_stall", 64'(mem_stall), 64'd0);
    tick();
    set_idle();
    #1;
    chk("sb_wb_pulse", 64'(wb_valid), 64'd1);
    tick();

    // Signed half load, ack in the third WAIT cycle.
    set_op(1'b0, 1'b1, 8'h03, 1'b0, 64'h2006, 64'h0, 64'h0, 5'd5, 2'b01);
    dmem_rdata = 64'h8001_0000_0000_0000;
    expect_wb(5'd5, 64'hFFFF_FFFF_FFFF_8001, 2'b01, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ack = 1'b1;
      #1;
      if (mem_stall) stalls++;
      if (i == 1) begin
        chk("lh_wait_addr", dmem_addr, 64'h2000);
        chk("lh_wait_wmask", 64'(dmem_wmask), 64'h00);
        chk("lh_wait_wbvalid", 64'(wb_valid), 64'd0);
      end
      tick();
    end
    set_idle();
    chk("lh_stall_cycles", 64'(stalls), 64'd3);
    tick();

    // Unsigned half load, ack in the first WAIT cycle.
    set_op(1'b0, 1'b1, 8'h03, 1'b1, 64'h2006, 64'h0, 64'h0, 5'd6, 2'b01);
    expect_wb(5'd6, 64'h8001, 2'b01, 1'b0, 1'b0);
    stalls = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) dmem_ack = 1'b1;
      #1;
      if (mem_stall) stalls++;
      tick();
    end
    set_idle();
    chk("lhu_stall_cycles", 64'(stalls), 64'd1);
    tick();

    // Signed byte load at offset 5, single-cycle latency.
    set_op(1'b0, 1'b1, 8'h01, 1'b0, 64'h7005, 64'h0, 64'h0, 5'd8, 2'b01);
    dmem_rdata = 64'h0000_9A00_0000_0000;
    dmem_ack   = 1'b1;
    expect_wb(5'd8, 64'hFFFF_FFFF_FFFF_FF9A, 2'b01, 1'b0, 1'b0);
    #1;
    chk("lb_stall", 64'(mem_stall), 64'd0);
    tick();
    set_idle();
    tick();

    // Misaligned word load: no request, no stall.
    set_op(1'b0, 1'b1, 8'h0F, 1'b0, 64'h3002, 64'h0, 64'h0, 5'd7, 2'b01);
    expect_wb(5'd7, 64'd0, 2'b11, 1'b1, 1'b0);
    #1;
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(mem_stall), 64'd0);
    tick();
    set_idle();
    tick();

    // Illegal width is treated as a full dword store.
    set_op(1'b1, 1'b0, 8'h07, 1'b0, 64'h6000, 64'h1122_3344_5566_7788, 64'h0, 5'd0, 2'b11);
    dmem_ack = 1'b1;
    expect_wb(5'd0, 64'd0, 2'b11, 1'b0, 1'b0);
    #1;
    chk("sd_wmask", 64'(dmem_wmask), 64'hFF);
    chk("sd_wdata", dmem_wdata, 64'h1122_3344_5566_7788);
    tick();
    set_idle();
    tick();

    // Timeout: ack never arrives.
    set_op(1'b0, 1'b1, 8'hFF, 1'b0, 64'h4000, 64'h0, 64'h0, 5'd9, 2'b01);
    expect_wb(5'd9, 64'd0, 2'b11, 1'b0, 1'b1);
    stalls = 0;
    reqs   = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (dmem_req) reqs++;
      if (mem_stall) stalls++;
      else done = 1'b1;
      tick();
    end
    chk("to_bounded", 64'(done), 64'd1);
    chk("to_req_cycles", 64'(reqs), 64'd17);
    chk("to_stall_cycles", 64'(stalls), 64'd17);
    set_op(1'b0, 1'b0, 8'h00, 1'b0, 64'h77, 64'h0, 64'h0, 5'd10, 2'b00);
    expect_wb(5'd10, 64'h77, 2'b00, 1'b0, 1'b0);
    #1;
    chk("to_next_stall", 64'(mem_stall), 64'd0);
    tick();
    set_idle();
    tick();
    tick();

    // Reset during the second WAIT cycle; a late ack must be ignored.
    set_op(1'b0, 1'b1, 8'hFF, 1'b0, 64'h5000, 64'h0, 64'h0, 5'd11, 2'b01);
    #1;
    chk("rw_stall", 64'(mem_stall), 64'd1);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst    = 1'b0;
    set_idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("rw_req", 64'(dmem_req), 64'd0);
    chk("rw_stall_after", 64'(mem_stall), 64'd0);
    chk("rw_wb_valid", 64'(wb_valid), 64'd0);
    chk("rw_wb_rd", 64'(wb_rd), 64'd0);
    tick();
    #1;
    chk("rw_late_ack", 64'(wb_valid), 64'd0);
    dmem_ack = 1'b0;
    tick();

    // Back-to-back ALU then link operations.
    set_op(1'b0, 1'b0, 8'h00, 1'b0, 64'h55, 64'h0, 64'h0, 5'd12, 2'b00);
    expect_wb(5'd12, 64'h55, 2'b00, 1'b0, 1'b0);
    #1;
    chk("b2b_stall0", 64'(mem_stall), 64'd0);
    tick();
    set_op(1'b0, 1'b0, 8'h00, 1'b0, 64'h999, 64'h0, 64'h104, 5'd13, 2'b10);
    expect_wb(5'd13, 64'h104, 2'b10, 1'b0, 1'b0);
    #1;
    chk("b2b_stall1", 64'(mem_stall), 64'd0);
    chk("b2b_first_pulse", 64'(wb_valid), 64'd1);
    tick();
    set_idle();
    #1;
    chk("b2b_second_pulse", 64'(wb_valid), 64'd1);
    tick();
    tick();
    tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
